// File: rtl/proc_pkg.sv
// Shared processor definitions: fetch FSM encoding and default datapath widths
// used by the processor, program BRAM and register file.
package proc_pkg;

  localparam int unsigned INSTR_WIDTH_DEF = 32;
  localparam int unsigned PC_BITS_DEF     = 9;

  typedef enum logic {
    FETCH = 1'b0,
    DONE  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch buffer holding {pc, instruction} entries; DEPTH must be a power of two.
module fetch_fifo #(
  parameter int unsigned WIDTH = 41,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head_data,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;
  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/fetch_unit.sv
// Prefetching instruction front end: sequential BRAM reads into a small FIFO, redirect flush, halt at end.
// Optional FETCH_PERF_CNT_EN adds saturating stat_fetched / stat_flushed counters.
module fetch_unit
  import proc_pkg::*;
#(
  parameter int unsigned INSTR_WIDTH     = INSTR_WIDTH_DEF,
  parameter int unsigned PC_BITS         = PC_BITS_DEF,
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned PROG_START_ADDR = 0,
  parameter int unsigned PROG_END_ADDR   = 14
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   mem_en,
  output logic [PC_BITS-1:0]     mem_addr,
  input  logic [INSTR_WIDTH-1:0] mem_rdata,
  input  logic                   redirect_valid,
  input  logic [PC_BITS-1:0]     redirect_pc,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [INSTR_WIDTH-1:0] instr_data,
  output logic [PC_BITS-1:0]     instr_pc,
  output logic                   halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]            stat_fetched,
  output logic [31:0]            stat_flushed
`endif
);

  localparam int unsigned FIFO_W = INSTR_WIDTH + PC_BITS;
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e         state_q, state_d;
  logic [PC_BITS-1:0]   pc_q, pc_d;
  logic                 mem_en_q, mem_en_d;
  logic [PC_BITS-1:0]   mem_addr_q, mem_addr_d;
  logic                 rvalid_q, rvalid_d;
  logic [PC_BITS-1:0]   rpc_q, rpc_d;
  logic                 halted_q, halted_d;

  logic                 push_c, pop_c, issue_c;
  logic [PC_BITS-1:0]   issue_pc_c;
  logic [CNT_W-1:0]     count_next_c;
  logic [CNT_W-1:0]     fifo_count;
  logic                 fifo_empty, fifo_full;
  logic [FIFO_W-1:0]    fifo_head;

  fetch_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_c),
    .push_data ({rpc_q, mem_rdata}),
    .pop       (pop_c),
    .flush     (redirect_valid),
    .head_data (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  // The read issued last cycle returns now; issue decisions are registered so they
  // account for the FIFO occupancy after this edge plus that returning word.
  always_comb begin
    push_c       = rvalid_q & ~redirect_valid & ~fifo_full;
    pop_c        = ~fifo_empty & instr_ready & ~redirect_valid;
    count_next_c = redirect_valid ? '0 : fifo_count + CNT_W'(push_c) - CNT_W'(pop_c);
    rvalid_d     = mem_en_q & ~redirect_valid;
    rpc_d        = mem_addr_q;
    state_d      = state_q;
    pc_d         = pc_q;
    mem_en_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    if (redirect_valid) begin
      issue_pc_c = redirect_pc;
      issue_c    = (32'(redirect_pc) <= PROG_END_ADDR);
      state_d    = issue_c ? FETCH : DONE;
      pc_d       = redirect_pc;
    end else begin
      issue_pc_c = pc_q;
      issue_c    = (state_q == FETCH) &&
                   ((count_next_c + CNT_W'(rvalid_d)) < CNT_W'(FIFO_DEPTH));
    end
    if (issue_c) begin
      mem_en_d   = 1'b1;
      mem_addr_d = issue_pc_c;
      pc_d       = issue_pc_c + PC_BITS'(1);
      if (issue_pc_c == PC_BITS'(PROG_END_ADDR)) begin
        state_d = DONE;
      end
    end
    halted_d = (state_d == DONE) && (count_next_c == '0) && !rvalid_d && !mem_en_d;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= FETCH;
      pc_q       <= PC_BITS'(PROG_START_ADDR);
      mem_en_q   <= 1'b0;
      mem_addr_q <= PC_BITS'(PROG_START_ADDR);
      rvalid_q   <= 1'b0;
      rpc_q      <= '0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      mem_en_q   <= mem_en_d;
      mem_addr_q <= mem_addr_d;
      rvalid_q   <= rvalid_d;
      rpc_q      <= rpc_d;
      halted_q   <= halted_d;
    end
  end

  assign mem_en      = mem_en_q;
  assign mem_addr    = mem_addr_q;
  assign instr_valid = ~fifo_empty;
  assign instr_data  = fifo_head[INSTR_WIDTH-1:0];
  assign instr_pc    = fifo_head[FIFO_W-1:INSTR_WIDTH];
  assign halted      = halted_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stat_fetched_q, stat_fetched_d;
  logic [31:0] stat_flushed_q, stat_flushed_d;
  logic [32:0] flush_sum_c;

  // Discards on redirect: buffered entries, the word returning now and the read issued now.
  always_comb begin
    stat_fetched_d = stat_fetched_q;
    stat_flushed_d = stat_flushed_q;
    flush_sum_c    = {1'b0, stat_flushed_q} + 33'(fifo_count) + 33'(rvalid_q) + 33'(mem_en_q);
    if (push_c && (stat_fetched_q != '1)) begin
      stat_fetched_d = stat_fetched_q + 32'd1;
    end
    if (redirect_valid) begin
      stat_flushed_d = flush_sum_c[32] ? '1 : flush_sum_c[31:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stat_fetched_q <= '0;
      stat_flushed_q <= '0;
    end else begin
      stat_fetched_q <= stat_fetched_d;
      stat_flushed_q <= stat_flushed_d;
    end
  end

  assign stat_fetched = stat_fetched_q;
  assign stat_flushed = stat_flushed_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: expected instruction stream modelled as "next PC owed to decode".
module tb_fetch_unit;

  localparam int END_A = 14;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        reset_w = 1'b0;
  logic        mem_en;
  logic [8:0]  mem_addr;
  logic [31:0] mem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [8:0]  redirect_pc = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr_data;
  logic [8:0]  instr_pc;
  logic        halted;

  logic        w_mem_en;
  logic [3:0]  w_mem_addr;
  logic [31:0] w_rdata = '0;
  logic        w_valid;
  logic [31:0] w_data;
  logic [3:0]  w_pc;
  logic        w_halted;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stat_fetched, stat_flushed;
  logic [31:0] w_stat_fetched, w_stat_flushed;
`endif

  always #5 clk = ~clk;

  // Program BRAM models: word at address a is 0x100 + a, one-cycle read latency.
  always @(posedge clk) if (mem_en) mem_rdata <= 32'h100 + 32'(mem_addr);
  always @(posedge clk) if (w_mem_en) w_rdata <= 32'h100 + 32'(w_mem_addr);

  fetch_unit #(
    .INSTR_WIDTH(32), .PC_BITS(9), .FIFO_DEPTH(4), .PROG_START_ADDR(0), .PROG_END_ADDR(14)
  ) dut (
    .clk(clk), .reset(reset), .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr_data(instr_data), .instr_pc(instr_pc), .halted(halted)
`ifdef FETCH_PERF_CNT_EN
    , .stat_fetched(stat_fetched), .stat_flushed(stat_flushed)
`endif
  );

  fetch_unit #(
    .INSTR_WIDTH(32), .PC_BITS(4), .FIFO_DEPTH(4), .PROG_START_ADDR(14), .PROG_END_ADDR(15)
  ) dut_w (
    .clk(clk), .reset(reset_w), .mem_en(w_mem_en), .mem_addr(w_mem_addr), .mem_rdata(w_rdata),
    .redirect_valid(1'b0), .redirect_pc(4'd0), .instr_valid(w_valid),
    .instr_ready(1'b1), .instr_data(w_data), .instr_pc(w_pc), .halted(w_halted)
`ifdef FETCH_PERF_CNT_EN
    , .stat_fetched(w_stat_fetched), .stat_flushed(w_stat_flushed)
`endif
  );

  int total = 0;
  int bad = 0;
  int exp_pc = 0;
  bit halted_exp = 1'b0;
  int stall = 0;

  int w_issued[$];
  int w_pcs[$];
  int w_datas[$];

  always @(negedge clk) begin
    if (reset_w) begin
      if (w_mem_en) w_issued.push_back(int'(w_mem_addr));
      if (w_valid) begin
        w_pcs.push_back(int'(w_pc));
        w_datas.push_back(int'(w_data));
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int remaining();
    return (exp_pc <= END_A) ? (END_A - exp_pc + 1) : 0;
  endfunction

  // Called at a falling edge: check this cycle's outputs, drive inputs, advance the model.
  task automatic step(input bit rdy, input bit rv, input int rpc);
    bit xfer;
    chk("halted", 64'(halted), 64'(halted_exp));
    if (mem_en) chk("issue_in_range", 64'(mem_addr <= 9'(END_A)), 64'd1);
    xfer = instr_valid && rdy && !rv;
    if (xfer) begin
      chk("pop_pc", 64'(instr_pc), 64'(exp_pc));
      chk("pop_data", 64'(instr_data), 64'(32'h100 + 32'(exp_pc)));
      exp_pc++;
      stall = 0;
    end
    instr_ready    = rdy;
    redirect_valid = rv;
    redirect_pc    = 9'(rpc);
    if (rv) begin
      exp_pc = rpc;
      stall  = 0;
    end else if (!xfer && rdy && remaining() > 0) begin
      stall++;
      if (stall > 8) begin
        chk("progress_timeout", 64'(stall), 64'd8);
        stall = 0;
      end
    end
    halted_exp = (remaining() == 0);
  endtask

  typedef struct {
    logic       e_en;
    logic [8:0] e_addr;
    logic       e_valid;
    logic [8:0] e_pc;
  } vec_t;

  initial begin
    vec_t tbl[6];
    bit found;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] flushed_before;
`endif
    tbl[0] = '{1'b1, 9'd0, 1'b0, 9'd0};
    tbl[1] = '{1'b1, 9'd1, 1'b0, 9'd0};
    tbl[2] = '{1'b1, 9'd2, 1'b1, 9'd0};
    tbl[3] = '{1'b1, 9'd3, 1'b1, 9'd1};
    tbl[4] = '{1'b1, 9'd4, 1'b1, 9'd2};
    tbl[5] = '{1'b1, 9'd5, 1'b1, 9'd3};

    repeat (3) @(negedge clk);
    chk("rst_mem_en", 64'(mem_en), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_valid", 64'(instr_valid), 64'd0);
    chk("rst_data", 64'(instr_data), 64'd0);
    chk("rst_pc", 64'(instr_pc), 64'd0);
    chk("rst_halted", 64'(halted), 64'd0);
    reset = 1'b1;
    reset_w = 1'b1;
    exp_pc = 0;
    halted_exp = 1'b0;

    // First cycles after release: issue every cycle, first instruction at cycle 3.
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("tbl_mem_en", 64'(mem_en), 64'(tbl[k].e_en));
      chk("tbl_mem_addr", 64'(mem_addr), 64'(tbl[k].e_addr));
      chk("tbl_valid", 64'(instr_valid), 64'(tbl[k].e_valid));
      if (tbl[k].e_valid) chk("tbl_pc", 64'(instr_pc), 64'(tbl[k].e_pc));
      step(1'b1, 1'b0, 0);
    end
    for (int i = 0; i < 60 && remaining() > 0; i++) begin
      @(negedge clk);
      step(1'b1, 1'b0, 0);
    end
    repeat (3) begin
      @(negedge clk);
      step(1'b1, 1'b0, 0);
    end
    chk("halted_after_run", 64'(halted), 64'd1);
`ifdef FETCH_PERF_CNT_EN
    chk("stat_fetched_run", 64'(stat_fetched), 64'd15);
`endif

    // Redirect to 0 after halt, then hold decode off long enough to fill the buffer.
    @(negedge clk);
    step(1'b1, 1'b1, 0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      step(1'b0, 1'b0, 0);
    end
    @(negedge clk);
    chk("stall_no_issue", 64'(mem_en), 64'd0);
    chk("stall_valid", 64'(instr_valid), 64'd1);
    chk("stall_pc", 64'(instr_pc), 64'd0);
    chk("stall_data", 64'(instr_data), 64'h100);
    step(1'b0, 1'b0, 0);
    @(negedge clk);
    chk("stall_data_hold", 64'(instr_data), 64'h100);

    // Release decode and run until PC 5 is at the head, then redirect to 2.
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (instr_valid && instr_pc == 9'd5) begin
        found = 1'b1;
        break;
      end
      step(1'b1, 1'b0, 0);
      @(negedge clk);
    end
    chk("found_head_pc5", 64'(found), 64'd1);
`ifdef FETCH_PERF_CNT_EN
    flushed_before = stat_flushed;
`endif
    step(1'b1, 1'b1, 2);
    @(negedge clk);
    chk("redir_gap1", 64'(instr_valid), 64'd0);
    step(1'b1, 1'b0, 0);
    @(negedge clk);
    chk("redir_gap2", 64'(instr_valid), 64'd0);
    step(1'b1, 1'b0, 0);
    @(negedge clk);
    chk("redir_valid_r3", 64'(instr_valid), 64'd1);
    chk("redir_pc_r3", 64'(instr_pc), 64'd2);
    step(1'b1, 1'b0, 0);
`ifdef FETCH_PERF_CNT_EN
    chk("stat_flushed_grew", 64'(stat_flushed > flushed_before), 64'd1);
`endif

    // Redirect beyond the program end: nothing issued, halt next cycle.
    repeat (2) begin
      @(negedge clk);
      step(1'b1, 1'b0, 0);
    end
    @(negedge clk);
    step(1'b1, 1'b1, 20);
    repeat (4) begin
      @(negedge clk);
      chk("far_redir_no_issue", 64'(mem_en), 64'd0);
      chk("far_redir_halted", 64'(halted), 64'd1);
      step(1'b1, 1'b0, 0);
    end

    // Randomised decode backpressure and redirects.
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      step(($urandom % 10) < 7, ($urandom % 20) == 0, int'($urandom % 18));
    end

    // Reset in the middle of a run wins over a concurrent redirect.
    @(negedge clk);
    step(1'b1, 1'b1, 0);
    repeat (5) begin
      @(negedge clk);
      step(1'b1, 1'b0, 0);
    end
    @(negedge clk);
    reset = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 9'd3;
    instr_ready = 1'b1;
    @(negedge clk);
    chk("midrst_mem_en", 64'(mem_en), 64'd0);
    chk("midrst_mem_addr", 64'(mem_addr), 64'd0);
    chk("midrst_valid", 64'(instr_valid), 64'd0);
    chk("midrst_pc", 64'(instr_pc), 64'd0);
    chk("midrst_halted", 64'(halted), 64'd0);
    reset = 1'b1;
    redirect_valid = 1'b0;
    exp_pc = 0;
    halted_exp = 1'b0;
    stall = 0;
    for (int i = 0; i < 60 && remaining() > 0; i++) begin
      @(negedge clk);
      step(1'b1, 1'b0, 0);
    end
    repeat (3) begin
      @(negedge clk);
      step(1'b1, 1'b0, 0);
    end
    chk("final_halted", 64'(halted), 64'd1);

    // Narrow-PC instance: fetches 14 and 15 only, never the wrapped address 0.
    chk("w_issue_count", 64'(w_issued.size()), 64'd2);
    chk("w_pop_count", 64'(w_pcs.size()), 64'd2);
    if (w_issued.size() == 2) begin
      chk("w_issue0", 64'(w_issued[0]), 64'd14);
      chk("w_issue1", 64'(w_issued[1]), 64'd15);
    end
    if (w_pcs.size() == 2) begin
      chk("w_pc0", 64'(w_pcs[0]), 64'd14);
      chk("w_pc1", 64'(w_pcs[1]), 64'd15);
      chk("w_data0", 64'(w_datas[0]), 64'h10E);
      chk("w_data1", 64'(w_datas[1]), 64'h10F);
    end
    chk("w_halted", 64'(w_halted), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction fetch unit that replaces the processor's single-word, stall-on-every-fetch program read with a prefetching front end. It issues sequential reads to the program BRAM (1-cycle read latency), buffers returned words with their PCs in a small FIFO, and presents them to decode over a valid/ready handshake. Taken branches and jumps redirect it, flushing buffered and in-flight words; it halts after fetching the last program address.

## Interface
- INSTR_WIDTH, 32, instruction word width (matches RAM_WIDTH of program BRAM)
- PC_BITS, 9, program address width (matches RAM_ADDR_BITS)
- FIFO_DEPTH, 4, prefetch buffer entries; power of two, ≥2
- PROG_START_ADDR, 0, PC loaded on reset
- PROG_END_ADDR, 14, last address fetched before halting
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-low; sampled low on a rising edge clears all state
- mem_en  out  1  program BRAM read enable
- mem_addr  out  PC_BITS  program BRAM read address
- mem_rdata  in  INSTR_WIDTH  BRAM read data, valid the cycle after mem_en
- redirect_valid  in  1  branch/jump taken this cycle
- redirect_pc  in  PC_BITS  target PC
- instr_valid  out  1  instr_data/instr_pc hold a valid instruction
- instr_ready  in  1  decode accepts the instruction
- instr_data  out  INSTR_WIDTH  instruction word (FIFO head)
- instr_pc  out  PC_BITS  PC of instr_data
- halted  out  1  end reached and pipeline drained
- stat_fetched, stat_flushed  out  32 each  present only with FETCH_PERF_CNT_EN

## Operation
- States: FETCH, DONE. Reset: state=FETCH, pc=PROG_START_ADDR, FIFO empty, inflight=0. Reset output values: mem_en=0, mem_addr=PROG_START_ADDR, instr_valid=0, instr_data=0, instr_pc=0, halted=0, counters=0.
- Issue: in FETCH, mem_en=1 when count+inflight<FIFO_DEPTH; mem_addr=pc; pc<=pc+1 (PC_BITS, wraps mod 2^PC_BITS). Issuing address PROG_END_ADDR moves state to DONE; no further issues.
- Return: the cycle after an issue, mem_rdata and its PC are pushed into the FIFO unless killed by a redirect.
- Credit rule guarantees no push into a full FIFO; push and pop in the same cycle are both performed.
- Pop: instr_valid=~empty; transfer when instr_valid&instr_ready. instr_data/instr_pc are stable while valid&~ready.
- Redirect (any state): FIFO cleared, in-flight read killed, pc<=redirect_pc, state<=FETCH; no issue in the redirect cycle. A pop in the same cycle is void (decode owns the branch instruction already). Redirect to a PC > PROG_END_ADDR: state<=DONE, nothing issued.
- halted = state==DONE & FIFO empty & inflight==0; cleared by redirect.
- reset low mid-operation overrides redirect and pops; in-flight data discarded.

## Timing
- Issue in cycle t -> data in FIFO at end of t+1 -> instr_valid in t+2 (2-cycle fetch latency).
- First mem_en in the first cycle after reset is released; first instr_valid two cycles later.
- Sustained throughput 1 instr/cycle when FIFO_DEPTH≥3 and decode always ready; FIFO_DEPTH=2 gives 1 per 2 cycles worst case.
- Redirect in cycle r: first issue at target in r+1, instr_valid at r+3.
- halted asserts the cycle after the last FIFO entry is popped.

## Configuration
- FETCH_PERF_CNT_EN defined: stat_fetched counts FIFO pushes, stat_flushed counts entries plus in-flight reads discarded by redirect; 32-bit, saturating, cleared by reset.
- Undefined: stat ports and counters absent; all other behaviour identical.

## Structure
- Shared package proc_pkg: fetch state encoding (FETCH, DONE), default PC_BITS/INSTR_WIDTH constants shared with processor, bram and regfile.
- Sub-module fetch_fifo: synchronous FIFO (width INSTR_WIDTH+PC_BITS, depth FIFO_DEPTH) with push, pop, flush, count, empty, full.

## Test plan
- Reset, instr_ready=1, program 0..14 = 0x100+addr -> instr_valid first at cycle 3 after release, PCs 0..14 consecutive, data 0x100..0x10E, halted one cycle after PC 14 popped.
- instr_ready low 10 cycles after first valid, FIFO_DEPTH=4 -> exactly 4 words buffered, mem_en low, instr_data stable at 0x100; on release no loss, no duplication.
- Redirect to 2 while head PC=5 -> PCs 6..8 never appear, next valid PC=2 three cycles later; stat_flushed increments by discarded count.
- Redirect to 0 after halted -> halted clears, program refetched from 0.
- Redirect to 20 (>PROG_END_ADDR) -> no mem_en, halted asserts once FIFO empty.
- PC_BITS=4, PROG_START_ADDR=14, PROG_END_ADDR=15 -> fetches 14, 15 then halts; pc wrap to 0 never issued.
